// File: rtl/aes_key_sched.sv
// AES-128 key-expansion engine: streams round keys 0..10 on a valid/ready port.
// Optional round-key store with registered random-access read, built when AES_KEY_SCHED_STORE_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; no key presented
// RUN   | presenting round key rnd_cnt, advancing on each handshake
module aes_key_sched #(
  parameter int NR = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_data,
  output logic         store_vld
);

  localparam logic [3:0] LAST = 4'(NR);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // G word transform: RotWord, SubWord, then Rcon into the top byte.
  function automatic logic [31:0] g_func(input logic [3:0] rnd_num, input logic [31:0] word_in);
    logic [31:0] rot;
    logic [7:0]  rcon;
    rot = {word_in[23:0], word_in[31:24]};
    case (rnd_num)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    return {SBOX[rot[31:24]] ^ rcon, SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [127:0]   cur_key;
  logic [3:0]     rnd_cnt;
  logic           done_q;
  logic           hs;
  logic           last;
  logic           load;
  logic [31:0]    g, n0, n1, n2, n3;

  assign hs   = (state_q == RUN) && rk_ready;
  assign last = (rnd_cnt == LAST);
  assign load = (state_q == IDLE) && start;

  assign g  = g_func(rnd_cnt + 4'd1, cur_key[31:0]);
  assign n0 = cur_key[127:96] ^ g;
  assign n1 = n0 ^ cur_key[95:64];
  assign n2 = n1 ^ cur_key[63:32];
  assign n3 = n2 ^ cur_key[31:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (hs && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cur_key <= '0;
      rnd_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= hs && last;
      if (load) begin
        cur_key <= key_in;
        rnd_cnt <= '0;
      end else if (hs && !last) begin
        cur_key <= {n0, n1, n2, n3};
        rnd_cnt <= rnd_cnt + 4'd1;
      end
    end
  end

  assign busy     = (state_q == RUN);
  assign rk_valid = (state_q == RUN);
  assign done     = done_q;
  assign rk_out   = (state_q == RUN) ? cur_key : '0;
  assign rk_idx   = (state_q == RUN) ? rnd_cnt : '0;

`ifdef AES_KEY_SCHED_STORE_EN
  logic [127:0] store_q [11];
  logic [127:0] rd_q;
  logic         vld_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 11; i++) store_q[i] <= '0;
      rd_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      if (hs) store_q[rnd_cnt] <= cur_key;
      rd_q <= (rd_addr <= LAST) ? store_q[rd_addr] : '0;
      if (load) vld_q <= 1'b0;
      else if (hs && last) vld_q <= 1'b1;
    end
  end

  assign rd_data   = rd_q;
  assign store_vld = vld_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data   = '0;
  assign store_vld = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched: FIPS-197 and zero-key schedules, backpressure,
// ignored start, mid-run reset and (store build) random-access reads.
module tb_aes_key_sched;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start;
  logic [127:0] key_in;
  logic         busy, done, rk_valid, rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;
  logic         store_vld;

  int checks   = 0;
  int failures = 0;

  logic [127:0] fips_rk [11];
  logic [127:0] exp_rk  [11];
  logic [127:0] fips_key;
  logic [127:0] alt_key;

  aes_key_sched #(.NR(10)) dut (
    .CLK(CLK), .RST(RST), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_out(rk_out), .rk_idx(rk_idx), .rd_addr(rd_addr), .rd_data(rd_data),
    .store_vld(store_vld)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"},      128'(busy),      128'(0));
    chk({tag, "_valid"},     128'(rk_valid),  128'(0));
    chk({tag, "_done"},      128'(done),      128'(0));
    chk({tag, "_rk_out"},    rk_out,          128'(0));
    chk({tag, "_rk_idx"},    128'(rk_idx),    128'(0));
    chk({tag, "_store_vld"}, 128'(store_vld), 128'(0));
    chk({tag, "_rd_data"},   rd_data,         128'(0));
  endtask

  // Pulses start with key, then walks the stream comparing against exp_rk.
  task automatic run_key(input logic [127:0] key, input bit rand_ready, input int chk_upto,
                         input int start_at, input int rst_at);
    int idx;
    int cyc;
    bit aborted;
    bit alt_sent;
    key_in   = key;
    start    = 1'b1;
    rk_ready = 1'b1;
    tick();
    key_in   = ~key;
    idx      = 0;
    cyc      = 1;
    aborted  = 1'b0;
    alt_sent = 1'b0;
    while (idx <= 10 && cyc < 300) begin
      start    = 1'b0;
      rk_ready = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
      chk($sformatf("busy_i%0d", idx),  128'(busy),     128'(1));
      chk($sformatf("valid_i%0d", idx), 128'(rk_valid), 128'(1));
      chk($sformatf("idx_i%0d", idx),   128'(rk_idx),   128'(idx));
      chk($sformatf("done_i%0d", idx),  128'(done),     128'(0));
      if (idx <= chk_upto) chk($sformatf("rk_i%0d", idx), rk_out, exp_rk[idx]);
      if (idx == start_at && !alt_sent) begin
        start    = 1'b1;
        key_in   = alt_key;
        alt_sent = 1'b1;
      end
      if (idx == rst_at) begin
        RST      = 1'b1;
        rk_ready = 1'b1;
        rd_addr  = 4'd1;
        tick();
        RST = 1'b0;
        check_idle_zero("rst_mid");
        tick();
        chk("rst_no_done", 128'(done), 128'(0));
        chk("rst_rd_cleared", rd_data, 128'(0));
        chk("rst_idle", 128'(rk_valid), 128'(0));
        aborted = 1'b1;
        break;
      end
      if (rk_ready) idx++;
      tick();
      cyc++;
    end
    start = 1'b0;
    if (!aborted) begin
      chk("handshakes", 128'(idx), 128'(11));
      chk("done_pulse", 128'(done), 128'(1));
      chk("busy_after", 128'(busy), 128'(0));
      chk("valid_after", 128'(rk_valid), 128'(0));
      if (!rand_ready) chk("done_latency", 128'(cyc), 128'(12));
    end
  endtask

  initial begin
    fips_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    alt_key    = 128'h000102030405060708090a0b0c0d0e0f;
    fips_rk[0] = fips_key;
    fips_rk[1] = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2] = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3] = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4] = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5] = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6] = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7] = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8] = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9] = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    exp_rk = fips_rk;

    // Reset held with start asserted: reset must win.
    RST      = 1'b1;
    start    = 1'b1;
    key_in   = fips_key;
    rk_ready = 1'b1;
    rd_addr  = 4'd0;
    tick();
    tick();
    RST   = 1'b0;
    start = 1'b0;
    check_idle_zero("reset");
    tick();
    chk("post_reset_idle", 128'(rk_valid), 128'(0));

    // FIPS-197 with ready tied high, then back-to-back with random backpressure.
    run_key(fips_key, 1'b0, 10, -1, -1);
    run_key(fips_key, 1'b1, 10, -1, -1);

`ifdef AES_KEY_SCHED_STORE_EN
    chk("store_vld", 128'(store_vld), 128'(1));
    rd_addr = 4'd1;
    tick();
    chk("rd_addr1", rd_data, fips_rk[1]);
    rd_addr = 4'd10;
    tick();
    chk("rd_addr10", rd_data, fips_rk[10]);
    rd_addr = 4'd12;
    tick();
    chk("rd_addr12", rd_data, 128'(0));
    rd_addr = 4'd0;
    tick();
    chk("rd_addr0", rd_data, fips_key);
`else
    chk("store_vld_off", 128'(store_vld), 128'(0));
    rd_addr = 4'd1;
    tick();
    chk("rd_data_off", rd_data, 128'(0));
`endif

    // All-zero key: only rounds 0 and 1 have hand-computed values.
    exp_rk[0] = 128'h0;
    exp_rk[1] = 128'h62636363626363636263636362636363;
    run_key(128'h0, 1'b0, 1, -1, -1);
    tick();
    chk("zero_idle_busy", 128'(busy), 128'(0));
    chk("zero_idle_valid", 128'(rk_valid), 128'(0));
    exp_rk = fips_rk;

    // start with another key at index 4 must be ignored.
    run_key(fips_key, 1'b0, 10, 4, -1);
    tick();

    // Reset at index 6, then a fresh full schedule.
    run_key(fips_key, 1'b0, 10, -1, 6);
    run_key(fips_key, 1'b0, 10, -1, -1);
`ifdef AES_KEY_SCHED_STORE_EN
    chk("store_vld_final", 128'(store_vld), 128'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

Sequential AES-128 key-expansion engine that drives the existing `G_func` word transform and produces the eleven 128-bit round keys, one per accepted handshake.
- It sits between the key-load interface and the cipher round datapath.
- It registers the cipher key, steps the round counter, feeds `G_func`, and combines the result into the next round key.
- It streams each key out on a valid/ready port and optionally retains all keys in an internal store for random-access reads.

## Interface
Parameters:
- `NR`, 10, last round index; the block is fixed to AES-128, so only 10 is legal.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  synchronous reset, active-high.
- `start`  in  1  load `key_in` and begin expansion; sampled only in IDLE.
- `key_in`  in  128  cipher key; w0 = [127:96], w3 = [31:0].
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse after round key 10 is accepted.
- `rk_valid`  out  1  `rk_out`/`rk_idx` hold a valid round key.
- `rk_ready`  in  1  consumer accepts the key when high together with `rk_valid`.
- `rk_out`  out  128  current round key.
- `rk_idx`  out  4  round index of `rk_out`, 0..10.
- `rd_addr`  in  4  store read address (store build only).
- `rd_data`  out  128  store read data (store build only).
- `store_vld`  out  1  the store holds a complete 11-key schedule (store build only).

## Operation
- FSM has two states: IDLE and RUN. Reset enters IDLE.
- IDLE:
  - `busy`=0 and `rk_valid`=0.
  - `start`=1 loads `cur_key` ← `key_in` and `rnd_cnt` ← 0, clears `store_vld`, and moves to RUN.
- RUN:
  - `busy`=1 and `rk_valid`=1.
  - `rk_out` = `cur_key` and `rk_idx` = `rnd_cnt`.
  - `start` is ignored.
- Next-key logic (combinational from `cur_key`):
  - `G_func` inputs are `rnd_num` = `rnd_cnt`+1 (4-bit) and `word_in` = w3.
  - Let g be the `G_func` output. Then n0 = w0^g, n1 = n0^w1, n2 = n1^w2, n3 = n2^w3.
  - Next key = {n0,n1,n2,n3}.
- Handshake (`rk_valid` & `rk_ready`):
  - If `rnd_cnt` < 10: `cur_key` ← next key and `rnd_cnt` ← `rnd_cnt`+1.
  - If `rnd_cnt` = 10: go to IDLE, pulse `done` on the following cycle, and set `store_vld`.
- Stall: with `rk_ready`=0, `rk_out`, `rk_idx` and `cur_key` hold indefinitely.
- `rnd_cnt` never exceeds 10. There is no wrap; values 11..15 are unreachable.

## Timing
- Reset values:
  - `busy`, `done`, `rk_valid`, `store_vld` = 0.
  - `rk_out` = 0 and `rk_idx` = 0.
  - `rd_data` = 0.
  - All store entries = 0.
- Latency:
  - `start` sampled at edge N → `rk_valid` high with `rk_idx`=0 from cycle N+1.
  - With `rk_ready` tied high, indices 0..10 appear on 11 consecutive cycles.
  - `done` pulses at cycle N+12, and `busy` is low from N+12.
- Back-to-back runs: `start` asserted in the same cycle as `done` is accepted, because the FSM is already in IDLE.
- `RST` mid-RUN: the next edge forces IDLE, zeroes all outputs and the store, and suppresses any `done` pulse.
- Simultaneous `RST` and `start`: reset wins.

## Configuration
- The macro `AES_KEY_SCHED_STORE_EN` selects whether the key store is built.
- Defined:
  - An 11×128 register store is built; entry `rnd_cnt` is written with `cur_key` on each handshake.
  - `rd_data` = store[`rd_addr`] is registered, with 1-cycle read latency.
  - `rd_addr` > 10 returns 0.
  - `store_vld` is driven as described above.
- Undefined:
  - No store is built.
  - `rd_data` is tied to 0 and `store_vld` is tied to 0.
  - `rd_addr` is unused. Streaming behaviour is identical to the defined build.

## Test plan
- FIPS-197 key, `rk_ready`=1: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, pulse `start` → checks below.
  - idx0 = `key_in`.
  - idx1 = a0fafe1788542cb123a339392a6c7605.
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` pulses 12 cycles after `start`.
- All-zero key → checks below.
  - idx0 = 0.
  - idx1 = 62636363626363636263636362636363.
  - Exactly 11 valid handshakes, then `busy`=0.
- Backpressure: toggle `rk_ready` randomly during the FIPS-197 run → same 11 keys in order, each held stable while `rk_ready`=0, no index skipped or repeated.
- `start` during RUN at idx 4 with a different key → ignored; the schedule completes with the original key.
- `RST` asserted at idx 6 → all outputs 0 next cycle, no `done`; a fresh `start` then produces the full correct schedule.
- Store (`AES_KEY_SCHED_STORE_EN` defined): after the FIPS-197 run → checks below.
  - `store_vld`=1.
  - `rd_addr`=1 gives a0fafe17… one cycle later.
  - `rd_addr`=10 gives d014f9a8….
  - `rd_addr`=12 gives 0.
